// File: rtl/msg_block_writer_if.sv
// Byte-stream input and block-memory write/handshake bundle for msg_block_writer.
// master is the writer side; slave is the byte source / memory / block consumer side.
interface msg_block_writer_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;
    logic                  wen;
    logic                  blk_valid;
    logic                  blk_last;
    logic                  blk_ack;

    modport master (
        input  in_data, in_valid, in_last, blk_ack,
        output in_ready, waddr, wdata, wen, blk_valid, blk_last
    );

    modport slave (
        output in_data, in_valid, in_last, blk_ack,
        input  in_ready, waddr, wdata, wen, blk_valid, blk_last
    );
endinterface

// File: rtl/msg_block_writer.sv
// Packs a big-endian byte stream into 16x32-bit SHA-256 blocks, appending the 0x80 marker,
// zero fill and 64-bit bit length, and hands each finished block to a consumer.
module msg_block_writer #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    msg_block_writer_if.master bus
);
    typedef enum logic [2:0] {StLoad, StPad80, StPadZ, StLen, StBlkWait} state_e;

    state_e      state_q;
    state_e      resume_q;
    logic [5:0]  bpos_q;
    logic [63:0] bitlen_q;
    // Only the three older bytes need storing; the newest byte is merged on the fly.
    logic [23:0] packer_q;
    logic        last_pend_q;

    logic        emit;
    logic [7:0]  emit_byte;
    state_e      after_emit;
    logic [31:0] packed_word;
    logic        blk_end;

    always_comb begin
        emit       = 1'b0;
        emit_byte  = 8'h00;
        after_emit = state_q;
        unique case (state_q)
            StLoad: begin
                emit       = bus.in_valid && bus.in_ready;
                emit_byte  = bus.in_data;
                after_emit = bus.in_last ? StPad80 : StLoad;
            end
            StPad80: begin
                emit       = 1'b1;
                emit_byte  = 8'h80;
                after_emit = StPadZ;
            end
            StPadZ: begin
                emit = (bpos_q != 6'd56);
            end
            StLen: begin
                emit      = 1'b1;
                // bpos 56..63 selects length bytes 7..0, most significant first
                emit_byte = bitlen_q[{~bpos_q[2:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign packed_word = {packer_q, emit_byte};
    assign blk_end     = emit && (bpos_q == 6'd63);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StLoad;
            resume_q      <= StLoad;
            bpos_q        <= 6'd0;
            bitlen_q      <= 64'd0;
            packer_q      <= 24'd0;
            last_pend_q   <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.waddr     <= '0;
            bus.wdata     <= 32'd0;
            bus.wen       <= 1'b0;
            bus.blk_valid <= 1'b0;
            bus.blk_last  <= 1'b0;
        end else begin
            bus.wen <= 1'b0;

            if (emit) begin
                packer_q <= packed_word[23:0];
                bpos_q   <= bpos_q + 6'd1;
                if (bpos_q[1:0] == 2'd3) begin
                    bus.wen   <= 1'b1;
                    bus.waddr <= ADDR_WIDTH'(bpos_q[5:2]);
                    bus.wdata <= packed_word;
                end
            end

            unique case (state_q)
                StLoad: begin
                    bus.in_ready <= !(emit && (bus.in_last || blk_end));
                    if (emit) begin
                        bitlen_q <= bitlen_q + 64'd8;
                    end
                end
                StPadZ: begin
                    if (!emit) begin
                        state_q <= StLen;
                    end
                end
                StBlkWait: begin
                    // First cycle here is the word-15 write; blk_valid follows it.
                    if (!bus.blk_valid) begin
                        bus.blk_valid <= 1'b1;
                        bus.blk_last  <= last_pend_q;
                    end else if (bus.blk_ack) begin
                        bus.blk_valid <= 1'b0;
                        bus.blk_last  <= 1'b0;
                        bpos_q        <= 6'd0;
                        if (bus.blk_last) begin
                            bitlen_q     <= 64'd0;
                            state_q      <= StLoad;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state_q      <= resume_q;
                            bus.in_ready <= (resume_q == StLoad);
                        end
                    end
                end
                default: ;
            endcase

            if (blk_end) begin
                state_q     <= StBlkWait;
                resume_q    <= after_emit;
                last_pend_q <= (state_q == StLen);
            end else if (emit) begin
                state_q <= after_emit;
            end
        end
    end
endmodule

// File: doc/msg_block_writer.md
MSG_BLOCK_WRITER -- requirements
Module: msg_block_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, word address width of the target block memory (16 words x 32 bits per SHA-256 block).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_data  input  8  message byte, big-endian order.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_last  input  1  final byte of message; qualified by in_valid.
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 SHALL have port waddr  output  ADDR_WIDTH  memory write word address.
REQ-009 SHALL have port wdata  output  32  memory write data.
REQ-010 SHALL have port wen  output  1  memory write enable, one cycle per word.
REQ-011 SHALL have port blk_valid  output  1  complete 16-word block resident in memory.
REQ-012 SHALL have port blk_last  output  1  block is the final padded block of the message; qualified by blk_valid.
REQ-013 SHALL have port blk_ack  input  1  consumer done with block; memory may be overwritten.

Function
REQ-014 SHALL register all outputs; waddr/wdata/wen SHALL change only on rising clk, stable through the following falling edge (memory captures on falling edge).
REQ-015 SHALL implement states LOAD, PAD80, PADZ, LEN, BLK_WAIT.
REQ-016 LOAD: in_ready=1; each accepted byte shifts into a 32-bit packer (first byte -> bits 31:24); byte position bpos (0..63) increments.
REQ-017 On acceptance of byte with bpos[1:0]==3, SHALL assert wen the next cycle with waddr=bpos[5:2], wdata=packed word.
REQ-018 SHALL count accepted message bytes; bit length = 8*bytes, 64-bit, wraps modulo 2^64.
REQ-019 Byte at bpos 63 in any state SHALL complete the block: wen for word 15 in cycle N, state BLK_WAIT, blk_valid=1 from cycle N+1.
REQ-020 in_last accepted -> PAD80 (unless block completed; then BLK_WAIT, resuming at PAD80 after ack); in_ready=0 until final block acknowledged.
REQ-021 PAD80: emit byte 0x80 in one cycle; next state PADZ.
REQ-022 PADZ: emit 0x00 per cycle until bpos==56 -> LEN; if bpos reaches 64 first, block completes with blk_last=0, then PADZ resumes at bpos 0.
REQ-023 LEN: emit 8 bytes of bit length, MSB first; bpos 63 completes block with blk_last=1.
REQ-024 BLK_WAIT: blk_valid=1, no wen, in_ready=0; blk_ack while blk_valid=1 SHALL drop blk_valid next cycle, reset bpos to 0, and resume the pending state (LOAD, PAD80 or PADZ); after a blk_last block, SHALL clear length counter and return to LOAD.
REQ-025 blk_ack SHALL be ignored when blk_valid=0; in_valid ignored when in_ready=0.
REQ-026 Zero-length messages SHALL be unsupported (in_last always accompanies a byte).

Reset
REQ-027 rst_n=0 at a rising edge SHALL force LOAD, bpos=0, length=0, packer=0, wen=0, waddr=0, wdata=0, blk_valid=0, blk_last=0, in_ready=0 during reset, 1 the first cycle after release.
REQ-028 Reset mid-block SHALL discard partial data; memory contents are not cleared.

Verification
REQ-029 "abc" (61,62,63,last) -> w0=0x61626380, w1..w14=0, w15=0x00000018, blk_valid=1, blk_last=1.
REQ-030 55-byte message -> one block, byte 55=0x80, w14=0, w15=0x000001B8, blk_last=1.
REQ-031 56-byte message -> block 1 w14=0x80000000, w15=0, blk_last=0; after ack block 2 w0..w14=0, w15=0x000001C0, blk_last=1.
REQ-032 64-byte message -> block 1 data only, blk_last=0; after ack block 2 w0=0x80000000, w15=0x00000200, blk_last=1.
REQ-033 blk_ack held low 10 cycles -> blk_valid held, in_ready=0, wen=0 throughout; ack -> blk_valid=0 next cycle.
REQ-034 Reset after 7 bytes accepted, then "abc" -> outputs 0 during reset, first wen at waddr 0 with w0=0x61626380, w15=0x00000018.
